// File: rtl/ex_scheduler_pkg.sv
// Shared sizing defaults for the execute-stage scheduler.
package ex_scheduler_pkg;
   localparam int RS_SZ    = 8;
   localparam int MULT_LAT = 4;
endpackage

// File: rtl/ex_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at or after ptr wins.
module rr_arbiter #(
   parameter int N = 8
)(
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int W = $clog2(N);

   logic [W-1:0] w_cand;

   // Scan from farthest offset down so the offset nearest ptr is written last.
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      w_cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_cand = ptr + W'(i);
         if (req[w_cand]) begin
            gnt     = 1'b1;
            gnt_idx = w_cand;
         end
      end
   end
endmodule

// File: rtl/ex_scheduler.sv
// Issues eligible entries to the single-cycle ALU and the pipelined multiplier,
// tracks in-flight ops and reports one completion per cycle.
module ex_scheduler
   import ex_scheduler_pkg::*;
#(
   parameter int RS_SZ    = ex_scheduler_pkg::RS_SZ,
   parameter int MULT_LAT = ex_scheduler_pkg::MULT_LAT
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     interrupt,
   input  logic [RS_SZ-1:0]         ex_valid,
   input  logic [RS_SZ-1:0]         ex_is_mult,
   output logic                     alu_start,
   output logic [$clog2(RS_SZ)-1:0] alu_idx,
   output logic                     mult_start,
   output logic [$clog2(RS_SZ)-1:0] mult_idx,
   output logic                     done_en,
   output logic [$clog2(RS_SZ)-1:0] done_idx,
   output logic                     busy
);
   localparam int IDX_W = $clog2(RS_SZ);

   logic               w_flush;
   logic [RS_SZ-1:0]   w_eligible;
   logic [RS_SZ-1:0]   w_alu_req;
   logic [RS_SZ-1:0]   w_mult_req;
   logic               w_alu_gnt;
   logic               w_mult_gnt;
   logic [IDX_W-1:0]   w_alu_gnt_idx;
   logic [IDX_W-1:0]   w_mult_gnt_idx;
   logic               w_alu_block;
   logic [RS_SZ-1:0]   w_started_next;

   logic [RS_SZ-1:0]   r_started;
   logic [IDX_W-1:0]   r_alu_ptr;
   logic [IDX_W-1:0]   r_mult_ptr;
   logic               r_alu_q_vld;
   logic [IDX_W-1:0]   r_alu_q_idx;
   logic [MULT_LAT-1:0] r_mult_vld;
   logic [IDX_W-1:0]   r_mult_idx [MULT_LAT];

   assign w_flush    = reset | interrupt;
   assign w_eligible = ex_valid & ~r_started;
   assign w_alu_req  = w_eligible & ~ex_is_mult;
   assign w_mult_req = w_eligible & ex_is_mult;

   rr_arbiter #(.N(RS_SZ)) u_alu_arb (
      .req     (w_alu_req),
      .ptr     (r_alu_ptr),
      .gnt     (w_alu_gnt),
      .gnt_idx (w_alu_gnt_idx)
   );

   rr_arbiter #(.N(RS_SZ)) u_mult_arb (
      .req     (w_mult_req),
      .ptr     (r_mult_ptr),
      .gnt     (w_mult_gnt),
      .gnt_idx (w_mult_gnt_idx)
   );

   // An ALU start now would complete alongside the mult op leaving the last stage.
   assign w_alu_block = r_mult_vld[MULT_LAT-2];

   assign alu_start  = w_alu_gnt & ~w_alu_block & ~w_flush;
   assign alu_idx    = alu_start ? w_alu_gnt_idx : '0;
   assign mult_start = w_mult_gnt & ~w_flush;
   assign mult_idx   = mult_start ? w_mult_gnt_idx : '0;

   assign done_en  = r_alu_q_vld | r_mult_vld[MULT_LAT-1];
   assign done_idx = r_mult_vld[MULT_LAT-1] ? r_mult_idx[MULT_LAT-1] :
                     (r_alu_q_vld ? r_alu_q_idx : '0);
   assign busy     = |r_started;

   always_comb begin
      w_started_next = r_started;
      if (done_en)    w_started_next[done_idx] = 1'b0;
      if (alu_start)  w_started_next[alu_idx]  = 1'b1;
      if (mult_start) w_started_next[mult_idx] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (w_flush) begin
         r_started   <= '0;
         r_alu_ptr   <= '0;
         r_mult_ptr  <= '0;
         r_alu_q_vld <= 1'b0;
         r_alu_q_idx <= '0;
         r_mult_vld  <= '0;
         for (int k = 0; k < MULT_LAT; k++) r_mult_idx[k] <= '0;
      end else begin
         r_started   <= w_started_next;
         r_alu_q_vld <= alu_start;
         r_alu_q_idx <= alu_idx;
         if (alu_start)  r_alu_ptr  <= alu_idx + 1'b1;
         if (mult_start) r_mult_ptr <= mult_idx + 1'b1;
         r_mult_vld    <= {r_mult_vld[MULT_LAT-2:0], mult_start};
         r_mult_idx[0] <= mult_idx;
         for (int k = 1; k < MULT_LAT; k++) r_mult_idx[k] <= r_mult_idx[k-1];
      end
   end

   a_single_done: assert property (@(posedge clock) disable iff (reset)
      !(r_alu_q_vld && r_mult_vld[MULT_LAT-1]));
endmodule

// File: tb/tb_ex_scheduler.sv
// Directed bench for ex_scheduler; completions are checked against a queue of
// expected (cycle, index) pairs pushed when the stimulus is applied.
module tb_ex_scheduler;
   localparam int RS = 8;
   localparam int ML = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       interrupt = 1'b0;
   logic [7:0] ex_valid = '0;
   logic [7:0] ex_is_mult = '0;
   logic       alu_start, mult_start, done_en, busy;
   logic [2:0] alu_idx, mult_idx, done_idx;

   ex_scheduler #(.RS_SZ(RS), .MULT_LAT(ML)) dut (
      .clock      (clock),
      .reset      (reset),
      .interrupt  (interrupt),
      .ex_valid   (ex_valid),
      .ex_is_mult (ex_is_mult),
      .alu_start  (alu_start),
      .alu_idx    (alu_idx),
      .mult_start (mult_start),
      .mult_idx   (mult_idx),
      .done_en    (done_en),
      .done_idx   (done_idx),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct {int cyc; int idx;} exp_t;
   exp_t sb[$];
   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_done(int c, int idx);
      exp_t e;
      e.cyc = c;
      e.idx = idx;
      sb.push_back(e);
   endtask

   task automatic check_done();
      exp_t e;
      if (done_en === 1'b1) begin
         if (sb.size() == 0) chk("done_unexpected", {31'b0, done_en}, 0);
         else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_idx", {29'b0, done_idx}, e.idx);
         end
      end else begin
         chk("done_idx_idle", {29'b0, done_idx}, 0);
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("done_missing", {31'b0, done_en}, 1);
         end
      end
   endtask

   // Also models the entry buffer dropping valid for a slot on its completion edge.
   task automatic tick();
      logic       drop;
      logic [2:0] di;
      check_done();
      drop = done_en;
      di   = done_idx;
      @(posedge clock);
      #1;
      if (drop) ex_valid[di] = 1'b0;
      cyc++;
   endtask

   task automatic chk_starts(string tag, logic as, int ai, logic ms, int mi);
      chk({tag, "_alu_start"},  {31'b0, alu_start},  {31'b0, as});
      chk({tag, "_alu_idx"},    {29'b0, alu_idx},    ai);
      chk({tag, "_mult_start"}, {31'b0, mult_start}, {31'b0, ms});
      chk({tag, "_mult_idx"},   {29'b0, mult_idx},   mi);
   endtask

   task automatic drain(string tag, int n);
      repeat (n) tick();
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_busy_end"}, {31'b0, busy}, 0);
      sb.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      interrupt = 1'b0;
      ex_valid = 8'hFF;
      ex_is_mult = 8'h0F;
      #1;
      chk_starts("rst_comb", 0, 0, 0, 0);
      @(posedge clock);
      #1;
      chk_starts("rst", 0, 0, 0, 0);
      chk("rst_done_en", {31'b0, done_en}, 0);
      chk("rst_done_idx", {29'b0, done_idx}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      reset = 1'b0;
      ex_valid = '0;
      ex_is_mult = '0;
      cyc = 0;
      sb.delete();
   endtask

   initial begin
      do_reset();

      // Two ALU entries back to back.
      ex_valid = 8'h05; ex_is_mult = 8'h00;
      expect_done(1, 0); expect_done(2, 2);
      #1; chk_starts("t1c0", 1, 0, 0, 0); chk("t1c0_busy", {31'b0, busy}, 0); tick();
      #1; chk_starts("t1c1", 1, 2, 0, 0); tick();
      #1; chk_starts("t1c2", 0, 0, 0, 0); chk("t1c2_busy", {31'b0, busy}, 1); tick();
      #1; chk("t1c3_busy", {31'b0, busy}, 0);
      drain("t1", 2);

      // Four multiplies fill the pipe.
      cyc = 0;
      ex_valid = 8'h0F; ex_is_mult = 8'h0F;
      for (int c = 0; c < 4; c++) expect_done(c + ML, c);
      for (int c = 0; c < 4; c++) begin
         #1; chk_starts($sformatf("t2c%0d", c), 0, 0, 1, c); tick();
      end
      for (int c = 4; c < 8; c++) begin
         #1; chk_starts($sformatf("t2c%0d", c), 0, 0, 0, 0); tick();
      end
      drain("t2", 2);

      // ALU start blocked when it would collide with a mult completion.
      cyc = 0;
      ex_valid = 8'h02; ex_is_mult = 8'h02;
      expect_done(4, 1);
      #1; chk_starts("t3c0", 0, 0, 1, 1); tick();
      #1; chk_starts("t3c1", 0, 0, 0, 0); tick();
      #1; chk_starts("t3c2", 0, 0, 0, 0); tick();
      ex_valid = ex_valid | 8'h10;
      expect_done(5, 4);
      #1; chk_starts("t3c3_blocked", 0, 0, 0, 0); tick();
      #1; chk_starts("t3c4", 1, 4, 0, 0); tick();
      #1; chk_starts("t3c5", 0, 0, 0, 0); tick();
      drain("t3", 2);

      // Round-robin fairness with every slot refilled each cycle.
      do_reset();
      ex_valid = 8'hFF; ex_is_mult = 8'h00;
      for (int c = 0; c < 8; c++) expect_done(c + 1, c);
      for (int c = 0; c < 8; c++) begin
         #1; chk_starts($sformatf("t4c%0d", c), 1, c, 0, 0); tick();
         ex_valid = 8'hFF;
      end
      ex_valid = 8'h80;
      drain("t4", 2);

      // Interrupt with two mults and one ALU op outstanding.
      cyc = 0;
      ex_valid = 8'h03; ex_is_mult = 8'h03;
      #1; chk_starts("t5c0", 0, 0, 1, 0); tick();
      ex_valid = 8'h07;
      expect_done(2, 2);
      #1; chk_starts("t5c1", 1, 2, 1, 1); tick();
      interrupt = 1'b1; ex_valid = 8'h1F; ex_is_mult = 8'h13;
      #1; chk_starts("t5c2_irq", 0, 0, 0, 0); tick();
      interrupt = 1'b0; ex_valid = 8'h00;
      for (int c = 3; c < 7; c++) begin
         #1;
         chk($sformatf("t5c%0d_done_en", c), {31'b0, done_en}, 0);
         chk($sformatf("t5c%0d_busy", c), {31'b0, busy}, 0);
         tick();
      end
      ex_valid = 8'hFF; ex_is_mult = 8'hAA;
      expect_done(8, 0); expect_done(7 + ML, 1);
      #1; chk_starts("t5c7_ptr0", 1, 0, 1, 1); tick();
      ex_valid = 8'h03;
      drain("t5", 5);

      // Reset with the multiplier pipe full.
      cyc = 0;
      ex_valid = 8'hF0; ex_is_mult = 8'hF0;
      expect_done(4, 4);
      for (int c = 0; c < 4; c++) begin
         #1; chk_starts($sformatf("t6c%0d", c), 0, 0, 1, 4 + c); tick();
      end
      reset = 1'b1; ex_valid = 8'hFF;
      #1; chk_starts("t6c4_rst", 0, 0, 0, 0); tick();
      reset = 1'b0; ex_valid = 8'h00;
      for (int c = 5; c < 9; c++) begin
         #1;
         chk($sformatf("t6c%0d_done_en", c), {31'b0, done_en}, 0);
         chk($sformatf("t6c%0d_busy", c), {31'b0, busy}, 0);
         tick();
      end
      ex_valid = 8'h91; ex_is_mult = 8'h10;
      expect_done(10, 0); expect_done(9 + ML, 4);
      #1; chk_starts("t6c9_lowest", 1, 0, 1, 4); tick();
      ex_valid = 8'h11;
      drain("t6", 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
